// File: rtl/pp_stream_array.sv
// pp_stream_array: three-stage valid/ready lane array doing bias add, activation, rounded requant and saturating clamp
module pp_stream_array #(
  parameter int LANES       = 32,
  parameter int ACC_W       = 32,
  parameter int SCALE_W     = 16,
  parameter int SCALE_Q     = 16,
  parameter int OUT_W       = 8,
  parameter int LEAKY_SHIFT = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*ACC_W-1:0]     acc_flat,
  input  logic [LANES*ACC_W-1:0]     bias_flat,
  input  logic [LANES*SCALE_W-1:0]   scale_flat,
  input  logic [1:0]                 act_mode,
  input  logic                       round_en,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*OUT_W-1:0]     result_flat,
  output logic [LANES-1:0]           sat_flags,
  output logic [15:0]                sat_count,
  input  logic                       sat_clr
);
  localparam int BW = ACC_W + 1;
  localparam int PW = ACC_W + SCALE_W + 2;
  localparam logic signed [PW-1:0] HALF = PW'(1) << (SCALE_Q - 1);
  localparam logic signed [PW-1:0] QMAX = PW'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [PW-1:0] QMIN = ~QMAX;

  logic                     r_v1, r_v2, r_v3;
  logic [LANES*BW-1:0]      r_b, r_a;
  logic [LANES*SCALE_W-1:0] r_sc1, r_sc2;
  logic [1:0]               r_m1;
  logic                     r_rnd1, r_rnd2;
  logic [LANES*OUT_W-1:0]   r_res;
  logic [LANES-1:0]         r_sat;
  logic [15:0]              r_cnt;
  logic                     w_adv;
  logic [LANES*BW-1:0]      w_b, w_a;
  logic [LANES*OUT_W-1:0]   w_res;
  logic [LANES-1:0]         w_sat;

  assign w_adv       = !r_v3 || out_ready;
  assign in_ready    = w_adv;
  assign out_valid   = r_v3;
  assign result_flat = r_res;
  assign sat_flags   = r_sat;
  assign sat_count   = r_cnt;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [BW-1:0] w_bv, w_lk, w_av;
    logic signed [PW-1:0] w_p, w_r, w_q;
    assign w_b[g*BW +: BW] = {acc_flat[(g+1)*ACC_W-1], acc_flat[g*ACC_W +: ACC_W]}
                           + {bias_flat[(g+1)*ACC_W-1], bias_flat[g*ACC_W +: ACC_W]};
    assign w_bv = r_b[g*BW +: BW];
    assign w_lk = w_bv >>> LEAKY_SHIFT;
    // mode[1] selects linear; otherwise mode[0] picks relu over leaky for negatives
    assign w_a[g*BW +: BW] = (!w_bv[BW-1] || r_m1[1]) ? w_bv : r_m1[0] ? '0 : w_lk;
    assign w_av = r_a[g*BW +: BW];
    assign w_p  = w_av * $signed({1'b0, r_sc2[g*SCALE_W +: SCALE_W]});
    assign w_r  = r_rnd2 ? w_p + HALF : w_p;
    assign w_q  = w_r >>> SCALE_Q;
    assign w_sat[g] = (w_q > QMAX) || (w_q < QMIN);
    assign w_res[g*OUT_W +: OUT_W] = w_q > QMAX ? {1'b0, {(OUT_W-1){1'b1}}} :
                                     w_q < QMIN ? {1'b1, {(OUT_W-1){1'b0}}} : w_q[OUT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_b    <= '0;
      r_a    <= '0;
      r_sc1  <= '0;
      r_sc2  <= '0;
      r_m1   <= '0;
      r_rnd1 <= 1'b0;
      r_rnd2 <= 1'b0;
      r_res  <= '0;
      r_sat  <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_adv) begin
        r_v1 <= in_valid;
        r_v2 <= r_v1;
        r_v3 <= r_v2;
      end
      if (w_adv && in_valid) begin
        r_b    <= w_b;
        r_sc1  <= scale_flat;
        r_m1   <= act_mode;
        r_rnd1 <= round_en;
      end
      if (w_adv && r_v1) begin
        r_a    <= w_a;
        r_sc2  <= r_sc1;
        r_rnd2 <= r_rnd1;
      end
      if (w_adv && r_v2) begin
        r_res <= w_res;
        r_sat <= w_sat;
      end
      if (sat_clr) r_cnt <= '0;
      else if (r_v3 && out_ready && |r_sat && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_pp_stream_array.sv
// tb_pp_stream_array: table vectors plus scoreboard for the streaming post-process array
module tb_pp_stream_array;
  localparam int L = 32;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1, round_en = 0, sat_clr = 0;
  logic in_ready, out_valid;
  logic [L*32-1:0] acc_flat = '0, bias_flat = '0;
  logic [L*16-1:0] scale_flat = '0;
  logic [1:0] act_mode = '0;
  logic [L*8-1:0] result_flat;
  logic [L-1:0] sat_flags;
  logic [15:0] sat_count;

  always #5 clk = ~clk;

  pp_stream_array dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .acc_flat(acc_flat), .bias_flat(bias_flat), .scale_flat(scale_flat),
    .act_mode(act_mode), .round_en(round_en), .out_valid(out_valid), .out_ready(out_ready),
    .result_flat(result_flat), .sat_flags(sat_flags), .sat_count(sat_count), .sat_clr(sat_clr)
  );

  typedef struct {
    logic [31:0] acc, bias;
    logic [15:0] scale;
    logic [1:0]  mode;
    logic        rnd;
    logic [7:0]  res;
    logic        sat;
  } row_t;
  typedef struct {
    logic [L*8-1:0] res;
    logic [L-1:0]   sat;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0, n_bad = 0;
  logic held = 0;
  logic [L*8-1:0] pres;
  logic [L-1:0] psat;

  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [8:0] model(logic [31:0] a, logic [31:0] b, logic [15:0] s, logic [1:0] m, logic r);
    longint x, p, q;
    x = longint'($signed(a)) + longint'($signed(b));
    if (x < 0 && m == 2'd0) x = x >>> 3;
    else if (x < 0 && m == 2'd1) x = 0;
    p = x * longint'({48'd0, s}) + (r ? 64'sd32768 : 64'sd0);
    q = p >>> 16;
    if (q > 127) return {1'b1, 8'h7F};
    if (q < -128) return {1'b1, 8'h80};
    return {1'b0, q[7:0]};
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    logic [8:0] m;
    for (int i = 0; i < L; i++) begin
      m = model(acc_flat[i*32 +: 32], bias_flat[i*32 +: 32], scale_flat[i*16 +: 16], act_mode, round_en);
      e.res[i*8 +: 8] = m[7:0];
      e.sat[i] = m[8];
    end
    return e;
  endfunction

  function automatic row_t rnd_row();
    row_t r;
    r.acc = 32'($urandom_range(0, 4000)) - 32'd2000;
    r.bias = 32'($urandom_range(0, 400)) - 32'd200;
    r.scale = 16'($urandom);
    r.mode = 2'($urandom);
    r.rnd = 1'($urandom);
    r.res = '0;
    r.sat = 1'b0;
    return r;
  endfunction

  task automatic load(row_t r);
    for (int i = 0; i < L; i++) begin
      acc_flat[i*32 +: 32] = (i == 0) ? r.acc : 32'($urandom_range(0, 6000)) - 32'd3000;
      bias_flat[i*32 +: 32] = (i == 0) ? r.bias : 32'($urandom_range(0, 600)) - 32'd300;
      scale_flat[i*16 +: 16] = (i == 0) ? r.scale : 16'($urandom);
    end
    act_mode = r.mode;
    round_en = r.rnd;
  endtask

  // drives one beat into an empty pipeline; returns in the cycle its result first shows
  task automatic run_row(row_t r, string nm);
    int lat;
    load(r);
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1 lat++;
    end
    chk({nm, "_lat"}, lat, 3);
    chk({nm, "_res0"}, result_flat[7:0], r.res);
    chk({nm, "_sat0"}, sat_flags[0], r.sat);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (held) begin
        chk("stall_hold_res", result_flat, pres);
        chk("stall_hold_sat", sat_flags, psat);
        chk("stall_hold_valid", out_valid, 1);
      end
      if (out_valid && !out_ready) chk("in_ready_stall", in_ready, 0);
      held = out_valid && !out_ready;
      pres = result_flat;
      psat = sat_flags;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: got result %0h with empty scoreboard", result_flat);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_res", result_flat, e.res);
          chk("sb_sat", sat_flags, e.sat);
        end
      end
      if (in_valid && in_ready) sb.push_back(expect_now());
    end else held = 0;
  end

  row_t tbl[13];
  row_t r;
  logic [15:0] c0;
  logic [3:0] pat = 4'b1001;
  logic acc_now;
  int idx, cyc;

  initial begin
    tbl = '{
      '{32'd1000,     32'd24,  16'h8000, 2'd0, 1'b0, 8'd127,  1'b1},
      '{-32'sd100,    32'd0,   16'h8000, 2'd0, 1'b0, 8'hF9,   1'b0},
      '{-32'sd100,    32'd0,   16'h8000, 2'd1, 1'b0, 8'h00,   1'b0},
      '{-32'sd100,    32'd0,   16'h8000, 2'd2, 1'b0, 8'hCE,   1'b0},
      '{-32'sd100,    32'd0,   16'h8000, 2'd3, 1'b0, 8'hCE,   1'b0},
      '{32'd3,        32'd0,   16'h8000, 2'd2, 1'b0, 8'd1,    1'b0},
      '{32'd3,        32'd0,   16'h8000, 2'd2, 1'b1, 8'd2,    1'b0},
      '{-32'sd3,      32'd0,   16'h8000, 2'd2, 1'b0, 8'hFE,   1'b0},
      '{-32'sd3,      32'd0,   16'h8000, 2'd2, 1'b1, 8'hFF,   1'b0},
      '{32'd50,       32'd0,   16'hFFFF, 2'd0, 1'b0, 8'd49,   1'b0},
      '{32'd50,       32'd0,   16'hFFFF, 2'd0, 1'b1, 8'd50,   1'b0},
      '{-32'sd4000,   32'd0,   16'hFFFF, 2'd0, 1'b0, 8'h80,   1'b1},
      '{32'd40,       32'd2,   16'hFFFF, 2'd1, 1'b0, 8'd41,   1'b0}
    };
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_res", result_flat, 0);
    chk("rst_sat", sat_flags, 0);
    chk("rst_cnt", sat_count, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 13; i++) begin
      run_row(tbl[i], $sformatf("row%0d", i));
      @(posedge clk);
      #1;
    end
    run_row('{32'h7FFFFFFF, 32'd1, 16'hFFFF, 2'd2, 1'b0, 8'd127, 1'b1}, "ovf_pos");
    c0 = sat_count;
    @(posedge clk);
    #1 chk("cnt_inc", sat_count, c0 + 16'd1);
    run_row('{32'h80000000, 32'hFFFFFFFF, 16'hFFFF, 2'd2, 1'b0, 8'h80, 1'b1}, "ovf_neg");
    sat_clr = 1;
    @(posedge clk);
    #1 sat_clr = 0;
    chk("cnt_clr", sat_count, 0);
    run_row(tbl[0], "after_clr");
    @(posedge clk);
    #1 chk("cnt_after_clr", sat_count, 1);
    idx = 0;
    cyc = 0;
    load(rnd_row());
    in_valid = 1;
    while (idx < 8 && cyc < 200) begin
      out_ready = pat[cyc % 4];
      @(negedge clk);
      acc_now = in_ready;
      @(posedge clk);
      #1 cyc++;
      if (acc_now) begin
        idx++;
        if (idx < 8) load(rnd_row());
      end
    end
    in_valid = 0;
    out_ready = 1;
    chk("bp_accepted", idx, 8);
    cyc = 0;
    while (sb.size() > 0 && cyc < 50) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk("bp_drain", sb.size(), 0);
    r = '{32'd100000, 32'd0, 16'hFFFF, 2'd2, 1'b0, 8'd127, 1'b1};
    load(r);
    in_valid = 1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    #1 rst_n = 0;
    #1;
    sb.delete();
    chk("midrst_valid", out_valid, 0);
    chk("midrst_cnt", sat_count, 0);
    chk("midrst_res", result_flat, 0);
    chk("midrst_sat", sat_flags, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (3) begin
      @(posedge clk);
      #1 chk("post_rst_idle", out_valid, 0);
    end
    run_row(tbl[3], "post_rst");
    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
